// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two prioritised write
// ports, optional same-cycle write bypass, and a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  we0,
  input  logic [$clog2(NREGS)-1:0] dst0_num,
  input  logic [XLEN-1:0]       dst0_value,
  input  logic                  we1,
  input  logic [$clog2(NREGS)-1:0] dst1_num,
  input  logic [XLEN-1:0]       dst1_value,
  input  logic [NREAD*$clog2(NREGS)-1:0] rd_num,
  output logic [NREAD*XLEN-1:0] rd_value
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t         state;
  state_t         state_next;
  logic [AW-1:0]  clr_idx;
  logic           sweep_done;
  logic           wr_ok0;
  logic           wr_ok1;
  logic [XLEN-1:0] regs [NREGS];

  assign sweep_done = (clr_idx == AW'(NREGS - 1));

  // Writes to register 0 are discarded outright when it is hardwired to zero.
  assign wr_ok0 = we0 && !(ZERO_REG && (dst0_num == '0));
  assign wr_ok1 = we1 && !(ZERO_REG && (dst1_num == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR)
        clr_idx <= sweep_done ? '0 : clr_idx + 1'b1;
      else if (clr)
        clr_idx <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (sweep_done) state_next = READY;
      READY:   if (clr)        state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // Port 1 is written last so it wins when both ports target the same entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        if (wr_ok0) regs[dst0_num] <= dst0_value;
        if (wr_ok1) regs[dst1_num] <= dst1_value;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = rd_num[i*AW +: AW];

    always_comb begin
      if (state == CLEAR || (ZERO_REG && addr == '0))
        val = '0;
      else if (BYPASS && wr_ok1 && dst1_num == addr)
        val = dst1_value;
      else if (BYPASS && wr_ok0 && dst0_num == addr)
        val = dst0_value;
      else
        val = regs[addr];
    end

    assign rd_value[i*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass+zero-reg, and neither) share stimulus
// and are checked every cycle against an array model, plus literal spot checks.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 3;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset = 1'b1;
  logic                   clr = 1'b0;
  logic                   we0 = 1'b0;
  logic                   we1 = 1'b0;
  logic [AW-1:0]          dst0_num = '0;
  logic [AW-1:0]          dst1_num = '0;
  logic [XLEN-1:0]        dst0_value = '0;
  logic [XLEN-1:0]        dst1_value = '0;
  logic [NREAD*AW-1:0]    rd_num = '0;
  logic                   busy_a;
  logic                   busy_b;
  logic [NREAD*XLEN-1:0]  rd_value_a;
  logic [NREAD*XLEN-1:0]  rd_value_b;

  int assertions = 0;
  int failures   = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_a),
    .we0(we0), .dst0_num(dst0_num), .dst0_value(dst0_value),
    .we1(we1), .dst1_num(dst1_num), .dst1_value(dst1_value),
    .rd_num(rd_num), .rd_value(rd_value_a)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_b),
    .we0(we0), .dst0_num(dst0_num), .dst0_value(dst0_value),
    .we1(we1), .dst1_num(dst1_num), .dst1_value(dst1_value),
    .rd_num(rd_num), .rd_value(rd_value_b)
  );

  // Model: architectural contents per instance plus cycles of clearing left.
  logic [XLEN-1:0] mem [2][NREGS];
  int              remaining  = 0;
  bit              modelValid = 1'b0;

  function automatic bit instBypass(input int inst);
    return (inst == 0);
  endfunction

  function automatic bit instZero(input int inst);
    return (inst == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      remaining  <= NREGS;
      modelValid <= 1'b1;
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
      if (remaining == 1)
        for (int i = 0; i < 2; i++)
          for (int r = 0; r < NREGS; r++)
            mem[i][r] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we0 && !(instZero(i) && dst0_num == 0)) mem[i][dst0_num] <= dst0_value;
        if (we1 && !(instZero(i) && dst1_num == 0)) mem[i][dst1_num] <= dst1_value;
      end
      if (clr) remaining <= NREGS;
    end
  end

  function automatic logic [XLEN-1:0] expRead(input int inst, input logic [AW-1:0] a);
    if (remaining > 0) return '0;
    if (instZero(inst) && a == 0) return '0;
    if (instBypass(inst) && we1 && dst1_num == a && !(instZero(inst) && a == 0)) return dst1_value;
    if (instBypass(inst) && we0 && dst0_num == a && !(instZero(inst) && a == 0)) return dst0_value;
    return mem[inst][a];
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid && !reset) begin
      checkOutput("busy_a", {31'b0, busy_a}, {31'b0, remaining > 0});
      checkOutput("busy_b", {31'b0, busy_b}, {31'b0, remaining > 0});
      for (int p = 0; p < NREAD; p++) begin
        checkOutput($sformatf("a.rd%0d", p), rd_value_a[p*XLEN +: XLEN], expRead(0, rd_num[p*AW +: AW]));
        checkOutput($sformatf("b.rd%0d", p), rd_value_b[p*XLEN +: XLEN], expRead(1, rd_num[p*AW +: AW]));
      end
    end
  end

  task automatic applyStimulus(input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] v0,
                               input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] v1,
                               input logic [NREAD*AW-1:0] rn, input logic c);
    we0 = w0; dst0_num = a0; dst0_value = v0;
    we1 = w1; dst1_num = a1; dst1_value = v1;
    rd_num = rn; clr = c;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NREAD*AW-1:0] rn);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, rn, 1'b0);
  endtask

  // Counts busy cycles (bounded) and leaves inputs untouched until after the next edge.
  task automatic waitReady(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_a) begin
        nextCycle();
        break;
      end
      n++;
      nextCycle();
    end
  endtask

  function automatic logic [NREAD*AW-1:0] reads(input int r2, input int r1, input int r0);
    return {AW'(r2), AW'(r1), AW'(r0)};
  endfunction

  int n;
  int m;

  initial begin
    // reset and initial sweep
    idle('0);
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    waitReady(n);
    checkOutput("t1 busy cycles", XLEN'(n), 32);
    for (int r = 0; r < NREGS; r++) begin
      idle(reads(r, r, r));
      @(negedge clk);
      checkOutput("t1 reg zero a", rd_value_a[XLEN-1:0], '0);
      checkOutput("t1 reg zero b", rd_value_b[2*XLEN +: XLEN], '0);
      nextCycle();
    end

    // single write then read
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, reads(0, 0, 0), 1'b0);
    nextCycle();
    idle(reads(5, 0, 5));
    @(negedge clk);
    checkOutput("t2 r5 a", rd_value_a[XLEN-1:0], 32'hDEADBEEF);
    checkOutput("t2 r0 a", rd_value_a[XLEN +: XLEN], 32'h0);
    checkOutput("t2 r5 b", rd_value_b[2*XLEN +: XLEN], 32'hDEADBEEF);
    nextCycle();

    // both ports to the same address
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, reads(7, 7, 7), 1'b0);
    @(negedge clk);
    checkOutput("t3 bypass a", rd_value_a[XLEN +: XLEN], 32'h22);
    checkOutput("t3 nobypass b", rd_value_b[XLEN +: XLEN], 32'h0);
    nextCycle();
    idle(reads(7, 7, 7));
    @(negedge clk);
    checkOutput("t3 r7 a", rd_value_a[XLEN-1:0], 32'h22);
    checkOutput("t3 r7 b", rd_value_b[XLEN-1:0], 32'h22);
    nextCycle();

    // port 1 bypass on read port 2
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hA5A5, reads(9, 0, 0), 1'b0);
    @(negedge clk);
    checkOutput("t4 bypass a", rd_value_a[2*XLEN +: XLEN], 32'hA5A5);
    checkOutput("t4 old b", rd_value_b[2*XLEN +: XLEN], 32'h0);
    nextCycle();
    idle(reads(9, 0, 0));
    @(negedge clk);
    checkOutput("t4 new b", rd_value_b[2*XLEN +: XLEN], 32'hA5A5);
    nextCycle();

    // register 0 handling
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, reads(0, 0, 0), 1'b0);
    @(negedge clk);
    checkOutput("t5 bypass r0 a", rd_value_a[XLEN-1:0], 32'h0);
    nextCycle();
    idle(reads(0, 0, 0));
    @(negedge clk);
    checkOutput("t5 r0 a", rd_value_a[XLEN-1:0], 32'h0);
    checkOutput("t5 r0 b", rd_value_b[XLEN-1:0], 32'hFFFF);
    nextCycle();

    // fill, clear, reset mid-sweep, writes during busy dropped
    for (int r = 1; r < NREGS; r++) begin
      applyStimulus(1'b1, AW'(r), 32'h1000_0000 + r, 1'b0, '0, '0, reads(r, r, r), 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, '0, '0, reads(3, 2, 1), 1'b1);
    nextCycle();
    for (int k = 1; k < 10; k++) begin
      applyStimulus(1'b1, AW'(k), $urandom, 1'b1, AW'(k + 10), $urandom, reads(k, 1, 2), 1'b0);
      @(negedge clk);
      checkOutput("t6 busy sweep", {31'b0, busy_a}, 32'h1);
      nextCycle();
    end
    idle('0);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    m = 0;
    applyStimulus(1'b1, 5'd4, 32'hBAD, 1'b1, 5'd6, 32'hBAD, reads(6, 4, 0), 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_a) m++;
      nextCycle();
    end
    idle('0);
    waitReady(n);
    checkOutput("t6 busy after reset", XLEN'(n + m), 32);
    for (int r = 0; r < NREGS; r++) begin
      idle(reads(r, r, r));
      @(negedge clk);
      checkOutput("t6 reg zero a", rd_value_a[XLEN-1:0], '0);
      checkOutput("t6 reg zero b", rd_value_b[XLEN +: XLEN], '0);
      nextCycle();
    end

    // randomized traffic, with collisions favoured by a narrow address range
    for (int c = 0; c < 2500; c++) begin
      logic [AW-1:0] a0, a1;
      logic [NREAD*AW-1:0] rn;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a0 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      a1 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rn = narrow ? reads($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3))
                  : NREAD*AW'($urandom);
      applyStimulus($urandom_range(0, 1) == 1, a0, $urandom,
                    $urandom_range(0, 1) == 1, a1, $urandom,
                    rn, $urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 299) == 0);
      nextCycle();
    end
    reset = 1'b0;
    idle('0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
